univ_shift_reg_n: RTL
=====================

# univ_shift_reg_n

Parametrised universal shift register with rotate, arithmetic-shift and counted-burst modes; the next generation of the team's 4-bit universal shift register. Each enabled cycle it either applies a per-cycle mode (hold, shift, load, rotate) or, after a `start` request, runs an autonomous burst of N identical shifts and reports completion. It serves as a serializer/deserializer and bit-alignment stage in datapath blocks.

## Interface
- `WIDTH`, 8: register width, minimum 2.
- `CNT_W`, 4: width of the burst count. Maximum burst is 2^CNT_W−1 shifts.

- `clk`  in  1: sole clock, rising edge.
- `clear_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: cycle enable. When low, every register holds, including state and count.
- `mode`  in  3: operation select.
- `in`  in  WIDTH: parallel load data.
- `serial_R`  in  1: serial input entering the MSB on a right shift.
- `serial_L`  in  1: serial input entering the LSB on a left shift.
- `start`  in  1: burst request.
- `count`  in  CNT_W: number of shifts in the burst.
- `out`  out  WIDTH: register contents.
- `ser_out_R`  out  1: `out[0]`, the bit leaving on a right shift (combinational from `out`).
- `ser_out_L`  out  1: `out[WIDTH-1]`, the bit leaving on a left shift (combinational from `out`).
- `busy`  out  1: a burst is in progress (registered).
- `done`  out  1: one-cycle pulse when a burst finishes (registered).

## Operation
- Mode codes:
  - 000: hold.
  - 001: shift right, `{serial_R, out[W-1:1]}`.
  - 010: shift left, `{out[W-2:0], serial_L}`.
  - 011: parallel load from `in`.
  - 100: rotate right.
  - 101: rotate left.
  - 110: arithmetic shift right, `{out[W-1], out[W-1:1]}`.
  - 111: reserved, behaves as hold.
- Shift-type modes are 001, 010, 100, 101 and 110.
- States: IDLE, BURST.
- IDLE, `en`=1, `start`=0: apply `mode` at each edge.
- IDLE, `en`=1, `start`=1: `out` is not changed at that edge.
  - If `count`≠0 and `mode` is shift-type: latch `mode` and `count` into the internal `rem` counter, go to BURST, set `busy`=1.
  - Otherwise: stay in IDLE and set `done`=1 for one cycle. This is a zero-length burst.
- BURST, `en`=1: at each edge, apply the latched mode and decrement `rem`.
  - When `rem`==1 at the edge, perform the last shift, go to IDLE, set `busy`=0 and `done`=1.
  - `serial_R` and `serial_L` are sampled live on every shift.
- BURST: `mode`, `in`, `count` and `start` are ignored. A new `start` is honoured only in IDLE.
- `en`=0 in any state: nothing changes. `done`, if it was high, stays high until the next enabled edge, then clears.
- `done` clears on the enabled edge after it was set, unless a new zero-length burst sets it again.
- Reset (`clear_n`=0 at an edge), which overrides `en` and works in any state:
  - `out`=0, `busy`=0, `done`=0, `rem`=0, state IDLE.
  - A burst interrupted by reset never pulses `done`.
- Reset values of the outputs: `ser_out_R`=0 and `ser_out_L`=0, since they follow `out`.

## Timing
- Per-cycle modes take effect at the same edge where `mode` is sampled. Latency is 1 cycle to `out`.
- Burst of N with `en` held high:
  - `start` is sampled at edge E0.
  - Shifts occur at edges E1..EN.
  - `busy` is high from after E0 through EN, N cycles in total.
  - `done` is high for the one cycle after EN, at the same time `busy` falls.
- Each cycle with `en` low during a burst adds one cycle to `busy`.
- Zero-length burst: `done` is high for the one cycle after E0; `busy` is never raised.
- Back-to-back bursts: `start` may be asserted in the same cycle `done` is high. The new burst is accepted at that edge.
- All outputs are glitch-free registers, except the two `ser_out` taps, which are direct wires from `out`.

## Test plan
- Reset, then `en`=1: load 8'hA5 (mode 011). Then:
  - mode 001 with `serial_R`=0 → 8'h52.
  - Reload; mode 010 with `serial_L`=1 → 8'h4B.
  - Reload; mode 110 → 8'hD2.
  - Reload; mode 101 → 8'h4B.
  - Reload; mode 100 → 8'hD2.
  - Mode 111 → unchanged.
- `out`=8'h81, `start` with mode 100 and `count`=3 → `busy` high for 3 cycles, `out` is 8'hC0, 8'h60, then 8'h30, `done` pulses once with `busy` low, and the IDLE mode applies afterwards.
- Same burst with `en` deasserted for 2 cycles after the first shift → `busy` high for 5 cycles, final `out`=8'h30, `done` pulses exactly once.
- `start` with `count`=0, and separately `start` with mode 011 → `done` pulses 1 cycle, `busy` stays 0, `out` is unchanged.
- `clear_n`=0 for one edge mid-burst (after 2 of 5 shifts) → `out`=0, `busy`=0, no `done`. A following `start` is accepted normally.
- Burst mode 010, `count`=8, `serial_L` toggling 1,0,1,0,… from `out`=0 → `out`=8'hAA. Random `mode` and `in` changes during the burst have no effect. `ser_out_L` tracks `out[7]` every cycle.

Source files
------------

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: parametrised universal shift register.
// Each enabled cycle applies a per-cycle mode (hold, shift, load, rotate,
// arithmetic shift), or after a start request runs an autonomous burst of
// identical shifts and pulses done when the burst completes.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             serial_R,
  input  logic             serial_L,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_R,
  output logic             ser_out_L,
  output logic             busy,
  output logic             done
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_BURST = 1'b1;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  localparam logic [CNT_W-1:0] REM_LAST = CNT_W'(1);

  logic             state;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] rem;
  logic [2:0]       op;
  logic [WIDTH-1:0] next_out;
  logic             mode_is_shift;

  // The serial taps are plain wires off the register ends.
  assign ser_out_R = out[0];
  assign ser_out_L = out[WIDTH-1];

  // Only the five shift-type codes may start a counted burst.
  assign mode_is_shift = (mode == MODE_SHR) || (mode == MODE_SHL) ||
                         (mode == MODE_ROR) || (mode == MODE_ROL) ||
                         (mode == MODE_ASR);

  // During a burst the latched mode drives the datapath; otherwise the live mode.
  always_comb begin
    op = (state == STATE_BURST) ? mode_q : mode;
  end

  // Candidate next register value for the selected operation; serial inputs are live.
  always_comb begin
    next_out = out;
    case (op)
      MODE_HOLD: next_out = out;
      MODE_SHR:  next_out = {serial_R, out[WIDTH-1:1]};
      MODE_SHL:  next_out = {out[WIDTH-2:0], serial_L};
      MODE_LOAD: next_out = in;
      MODE_ROR:  next_out = {out[0], out[WIDTH-1:1]};
      MODE_ROL:  next_out = {out[WIDTH-2:0], out[WIDTH-1]};
      MODE_ASR:  next_out = {out[WIDTH-1], out[WIDTH-1:1]};
      default:   next_out = out;
    endcase
  end

  // Register, burst control and status flags; reset wins over enable, and a disabled cycle freezes everything including done.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      out    <= '0;
      state  <= STATE_IDLE;
      mode_q <= MODE_HOLD;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            if ((count != '0) && mode_is_shift) begin
              mode_q <= mode;
              rem    <= count;
              state  <= STATE_BURST;
              busy   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            out <= next_out;
          end
        end
        default: begin
          out <= next_out;
          rem <= rem - 1'b1;
          if (rem == REM_LAST) begin
            state <= STATE_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
